// File: rtl/data_mem_responder.sv
// data_mem_responder: data-side RAM and memory-mapped I/O for the single-cycle core.
// Same-cycle reads, clocked writes, cycle counter, byte output FIFO, status flags.
module data_mem_responder #(
    parameter int bus       = 32,
    parameter int RAM_WORDS = 256,
    parameter int OUT_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [bus-1:0] memdir,
    input  logic [bus-1:0] memdataout,
    input  logic           MRE,
    input  logic           MWE,
    output logic [bus-1:0] memdatain,
    output logic [7:0]     out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           fault
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [bus-1:0] CYC_ADDR = bus'(32'hFFFF_0000);
    localparam logic [bus-1:0] OUT_ADDR = bus'(32'hFFFF_0004);
    localparam logic [bus-1:0] ST_ADDR  = bus'(32'hFFFF_0008);

    logic           aligned;
    logic           acc;
    logic           ram_hit;
    logic           cyc_hit;
    logic           out_hit;
    logic           st_hit;
    logic           bad;
    logic           st_wr;

    logic [bus-1:0] ram [RAM_WORDS];
    logic [AW-1:0]  ram_idx;

    logic [bus-1:0] cycle;

    logic [7:0]     fifo [OUT_DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  cnt;
    logic           empty;
    logic           full;
    logic           push;
    logic           pop;
    logic           do_push;
    logic           ovf_set;

    logic           ovf;
    logic           flt;
    logic [bus-1:0] status;

    assign aligned = memdir[1:0] == 2'b00;
    assign acc     = MRE | MWE;
    assign ram_hit = aligned && (memdir[bus-1:AW+2] == '0);
    assign cyc_hit = memdir == CYC_ADDR;
    assign out_hit = memdir == OUT_ADDR;
    assign st_hit  = memdir == ST_ADDR;
    assign bad     = acc && !(ram_hit || cyc_hit || out_hit || st_hit);
    assign st_wr   = MWE && st_hit;
    assign ram_idx = memdir[AW+1:2];

    // A push into a full FIFO only lands when a pop frees a slot that same edge.
    assign empty   = cnt == '0;
    assign full    = cnt == CW'(OUT_DEPTH);
    assign push    = MWE && out_hit;
    assign pop     = !empty && out_ready;
    assign do_push = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    assign status = bus'({8'(cnt), 4'b0000, flt, ovf, full, empty});

    // RAM word write; contents survive reset, so rst is deliberately ignored here.
    always_ff @(posedge clk) begin
        if (MWE && ram_hit) begin
            ram[ram_idx] <= memdataout;
        end
    end

    // Free-running cycle counter, loadable by a CYCLE write.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle <= '0;
        end else if (MWE && cyc_hit) begin
            cycle <= memdataout;
        end else begin
            cycle <= cycle + bus'(1);
        end
    end

    // FIFO storage; stale entries are harmless because the pointers reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo[wr_ptr] <= memdataout[7:0];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({do_push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky flags: a new event in the same cycle beats a W1C clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
            flt <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (st_wr && memdataout[2]) begin
                ovf <= 1'b0;
            end
            if (bad) begin
                flt <= 1'b1;
            end else if (st_wr && memdataout[3]) begin
                flt <= 1'b0;
            end
        end
    end

    // Combinational read mux; OUTDATA and faulting reads return 0.
    always_comb begin
        memdatain = '0;
        if (MRE) begin
            unique case (1'b1)
                ram_hit: memdatain = ram[ram_idx];
                cyc_hit: memdatain = cycle;
                st_hit:  memdatain = status;
                default: memdatain = '0;
            endcase
        end
    end

    assign out_valid = !empty;
    assign out_data  = empty ? 8'h00 : fifo[rd_ptr];
    assign fault     = flt;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed stimulus with queued expectations.
// A negedge monitor pops and compares reads, FIFO pops and flag probes.
module tb_data_mem_responder;

    localparam logic [31:0] CYC = 32'hFFFF_0000;
    localparam logic [31:0] OUT = 32'hFFFF_0004;
    localparam logic [31:0] ST  = 32'hFFFF_0008;

    logic        clk;
    logic        rst;
    logic [31:0] memdir;
    logic [31:0] memdataout;
    logic        MRE;
    logic        MWE;
    logic [31:0] memdatain;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        fault;

    typedef struct {
        string       nm;
        logic [31:0] exp;
    } rd_t;

    typedef struct {
        string      nm;
        logic       v;
        logic       f;
        logic [7:0] d;
    } pr_t;

    rd_t        rdq[$];
    logic [7:0] bq[$];
    pr_t        pq[$];

    int n_vec;
    int n_bad;
    bit done;

    data_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .memdir     (memdir),
        .memdataout (memdataout),
        .MRE        (MRE),
        .MWE        (MWE),
        .memdatain  (memdatain),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got=timeout need=finish");
        $fatal(1);
    end

    task automatic op(input logic re, input logic we,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp, input string nm);
        MRE        = re;
        MWE        = we;
        memdir     = a;
        memdataout = d;
        if (re) rdq.push_back('{nm, exp});
        @(posedge clk);
        #1;
        MRE = 1'b0;
        MWE = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        op(1'b0, 1'b1, a, d, 32'h0, "");
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp,
                      input string nm);
        op(1'b1, 1'b0, a, 32'h0, exp, nm);
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, "");
    endtask

    task automatic push(input logic [7:0] b, input bit keep);
        if (keep) bq.push_back(b);
        wr(OUT, {24'h0, b});
    endtask

    task automatic probe(input string nm, input logic v, input logic f,
                         input logic [7:0] d);
        pq.push_back('{nm, v, f, d});
    endtask

    // Scoreboard monitor: all comparisons happen here, away from the edge.
    always @(negedge clk) begin
        rd_t r;
        pr_t p;
        logic [7:0] eb;
        if (MRE) begin
            n_vec++;
            if (rdq.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_read addr=%h got=%h", memdir, memdatain);
            end else begin
                r = rdq.pop_front();
                if (memdatain !== r.exp) begin
                    n_bad++;
                    $display("FAIL %s got=%h need=%h", r.nm, memdatain, r.exp);
                end
            end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_vec++;
            if (bq.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pop got=%h need=none", out_data);
            end else begin
                eb = bq.pop_front();
                if (out_data !== eb) begin
                    n_bad++;
                    $display("FAIL fifo_byte got=%h need=%h", out_data, eb);
                end
            end
        end
        while (pq.size() != 0) begin
            p = pq.pop_front();
            n_vec++;
            if (out_valid !== p.v || fault !== p.f || out_data !== p.d) begin
                n_bad++;
                $display("FAIL %s got v=%b f=%b d=%h need v=%b f=%b d=%h",
                         p.nm, out_valid, fault, out_data, p.v, p.f, p.d);
            end
        end
        if (done) begin
            n_vec++;
            if (rdq.size() != 0 || bq.size() != 0) begin
                n_bad++;
                $display("FAIL leftover got reads=%0d bytes=%0d need 0 0",
                         rdq.size(), bq.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
            $finish;
        end
    end

    initial begin
        n_vec      = 0;
        n_bad      = 0;
        done       = 1'b0;
        rst        = 1'b1;
        MRE        = 1'b0;
        MWE        = 1'b0;
        memdir     = 32'h0;
        memdataout = 32'h0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        probe("reset_outputs", 1'b0, 1'b0, 8'h00);
        rd(CYC, 32'h0, "reset_cycle");
        rd(ST, 32'h1, "reset_status");

        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10, 32'hDEAD_BEEF, "ram_rd");
        op(1'b1, 1'b1, 32'h10, 32'h1, 32'hDEAD_BEEF, "ram_rw_old");
        rd(32'h10, 32'h1, "ram_rw_new");

        wr(32'h12, 32'h5);
        rd(32'h12, 32'h0, "misaligned_rd");
        rd(32'h8000, 32'h0, "unmapped_rd");
        rd(32'h10, 32'h1, "ram_unchanged");
        probe("fault_set", 1'b0, 1'b1, 8'h00);
        rd(ST, 32'h9, "fault_status");
        wr(ST, 32'h8);
        probe("fault_clr", 1'b0, 1'b0, 8'h00);
        rd(ST, 32'h1, "status_clr");

        probe("push_no_bypass", 1'b0, 1'b0, 8'h00);
        push(8'h41, 1'b1);
        probe("push_visible", 1'b1, 1'b0, 8'h41);
        push(8'h42, 1'b1);
        push(8'h43, 1'b1);
        push(8'h44, 1'b1);
        push(8'h45, 1'b0);
        rd(ST, 32'h0000_0406, "ovf_status");
        wr(ST, 32'h4);
        rd(ST, 32'h0000_0402, "ovf_clr_status");
        out_ready = 1'b1;
        repeat (4) idle();
        probe("drained", 1'b0, 1'b0, 8'h00);
        out_ready = 1'b0;
        rd(ST, 32'h1, "drained_status");

        push(8'h50, 1'b1);
        push(8'h51, 1'b1);
        push(8'h52, 1'b1);
        push(8'h53, 1'b1);
        rd(ST, 32'h0000_0402, "full_status");
        out_ready = 1'b1;
        push(8'h55, 1'b1);
        out_ready = 1'b0;
        rd(ST, 32'h0000_0402, "full_pp_status");
        out_ready = 1'b1;
        repeat (4) idle();
        probe("pp_drained", 1'b0, 1'b0, 8'h00);
        out_ready = 1'b0;

        wr(CYC, 32'h100);
        rd(CYC, 32'h100, "cyc_load");
        idle();
        idle();
        rd(CYC, 32'h103, "cyc_plus3");
        wr(CYC, 32'hFFFF_FFFE);
        rd(CYC, 32'hFFFF_FFFE, "cyc_fe");
        rd(CYC, 32'hFFFF_FFFF, "cyc_ff");
        rd(CYC, 32'h0, "cyc_wrap");
        rd(OUT, 32'h0, "outdata_rd");
        rd(ST, 32'h1, "status_after_od");

        push(8'h61, 1'b0);
        push(8'h62, 1'b0);
        wr(32'h20, 32'hCAFE_F00D);
        rd(32'h8000, 32'h0, "unmapped_rd2");
        probe("pre_rst", 1'b1, 1'b1, 8'h61);
        rst = 1'b1;
        wr(32'h24, 32'h1234_5678);
        rst = 1'b0;
        probe("post_rst", 1'b0, 1'b0, 8'h00);
        rd(CYC, 32'h0, "rst_cycle");
        rd(ST, 32'h1, "rst_status");
        rd(32'h20, 32'hCAFE_F00D, "ram_keep");
        rd(32'h24, 32'h1234_5678, "ram_wr_in_rst");
        rd(32'h10, 32'h1, "ram_keep_old");

        idle();
        done = 1'b1;
    end

endmodule
